// File: rtl/arith_pkg.sv
// Shared definitions for the team's arithmetic cells: default operand width
// and the state encoding used by the multi-cycle serial units.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = x - y, bout set when y exceeds x.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);

    assign d    = x ^ y;
    assign bout = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b computed LSB first over WIDTH cycles,
// with unsigned borrow and signed overflow flags registered on completion.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   res_sh;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;

    logic               d1;
    logic               bo1;
    logic               bo2;
    logic               dbit;
    logic               bout;
    logic [WIDTH-1:0]   res_next;

    // Full subtractor built from two half subtractors: (a - b) - borrow.
    half_subtractor u_hs_ab (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .d    (d1),
        .bout (bo1)
    );

    half_subtractor u_hs_bin (
        .x    (d1),
        .y    (borrow),
        .d    (dbit),
        .bout (bo2)
    );

    assign bout     = bo1 | bo2;
    assign res_next = {dbit, res_sh};

    // NOTE: every flop, including the operand shift registers, is reset so an
    // aborted operation leaves no stale state; all state updates use <=.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    borrow <= bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // On the last bit a_sh[0]/b_sh[0] hold the operand sign bits.
                        diff       <= res_next;
                        borrow_out <= bout;
                        overflow   <= (a_sh[0] ^ b_sh[0]) & (dbit ^ a_sh[0]);
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16 using an
// arithmetic reference model feeding per-width expectation queues.
module tb_serial_subtractor;

    typedef struct {
        logic [31:0] diff;
        logic        bo;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, bo8, ov8;
    logic [7:0]  diff8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, bo16, ov16;
    logic [15:0] diff16;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q8[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .overflow   (ov8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start16),
        .a          (a16),
        .b          (b16),
        .busy       (busy16),
        .done       (done16),
        .diff       (diff16),
        .borrow_out (bo16),
        .overflow   (ov16)
    );

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input int w);
        exp_t        e;
        logic [31:0] mask;
        logic [32:0] full;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full   = {1'b0, av & mask} - {1'b0, bv & mask};
        e.diff = full[31:0] & mask;
        e.bo   = (av & mask) < (bv & mask);
        e.ov   = (av[w-1] != bv[w-1]) && (e.diff[w-1] != av[w-1]);
        return e;
    endfunction

    // Drive one operation, scramble inputs after capture, then compare on done.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv);
        int   cyc;
        int   busy_n;
        exp_t e;
        q8.push_back(model({24'd0, av}, {24'd0, bv}, 8));
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = ~bv;
        cyc = 0; busy_n = 0;
        while (!done8 && cyc < 40) begin
            if (busy8) busy_n++;
            @(negedge clk);
            cyc++;
        end
        e = q8.pop_front();
        n_vec++;
        if (!done8) begin
            n_bad++;
            $display("FAIL op8_timeout a=%h b=%h: no done after %0d cycles, required 8", av, bv, cyc);
        end else begin
            if (cyc !== 8 || busy_n !== 8) begin
                n_bad++;
                $display("FAIL op8_latency a=%h b=%h: done after %0d busy %0d, required 8/8", av, bv, cyc, busy_n);
            end
            n_vec++;
            if ({diff8, bo8, ov8} !== {e.diff[7:0], e.bo, e.ov}) begin
                n_bad++;
                $display("FAIL op8_result a=%h b=%h: got diff=%h bo=%b ov=%b, required diff=%h bo=%b ov=%b",
                         av, bv, diff8, bo8, ov8, e.diff[7:0], e.bo, e.ov);
            end
            @(negedge clk);
            n_vec++;
            if (done8 !== 1'b0) begin
                n_bad++;
                $display("FAIL op8_done_width a=%h b=%h: done=%b one cycle later, required 0", av, bv, done8);
            end
        end
    endtask

    task automatic run_op16(input logic [15:0] av, input logic [15:0] bv);
        int   cyc;
        exp_t e;
        q16.push_back(model({16'd0, av}, {16'd0, bv}, 16));
        @(negedge clk);
        a16 = av; b16 = bv; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = ~av; b16 = ~bv;
        cyc = 0;
        while (!done16 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        e = q16.pop_front();
        n_vec++;
        if (!done16 || cyc !== 16) begin
            n_bad++;
            $display("FAIL op16_latency a=%h b=%h: done=%b after %0d cycles, required done at 16", av, bv, done16, cyc);
        end else if ({diff16, bo16, ov16} !== {e.diff[15:0], e.bo, e.ov}) begin
            n_bad++;
            $display("FAIL op16_result a=%h b=%h: got diff=%h bo=%b ov=%b, required diff=%h bo=%b ov=%b",
                     av, bv, diff16, bo16, ov16, e.diff[15:0], e.bo, e.ov);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy8, done8, diff8, bo8, ov8} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got busy=%b done=%b diff=%h bo=%b ov=%b, required all 0",
                     busy8, done8, diff8, bo8, ov8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy8, done8, diff8, bo8, ov8, busy16, done16, diff16, bo16, ov16} !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_release: got busy8=%b diff8=%h busy16=%b diff16=%h, required all 0",
                     busy8, diff8, busy16, diff16);
        end
    endtask

    task automatic test_basic();
        run_op8(8'h35, 8'h12);
    endtask

    task automatic test_borrow_hold();
        exp_t e;
        run_op8(8'h12, 8'h35);
        e = model(32'h12, 32'h35, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({done8, busy8, diff8, bo8, ov8} !== {2'b00, e.diff[7:0], e.bo, e.ov}) begin
                n_bad++;
                $display("FAIL hold_idle_%0d: got done=%b busy=%b diff=%h bo=%b ov=%b, required 0/0 diff=%h bo=%b ov=%b",
                         i, done8, busy8, diff8, bo8, ov8, e.diff[7:0], e.bo, e.ov);
            end
        end
    endtask

    task automatic test_overflow_edges();
        run_op8(8'h80, 8'h01);
        run_op8(8'h7F, 8'hFF);
        run_op8(8'h00, 8'hFF);
        run_op8(8'hFF, 8'h00);
        run_op8(8'hA5, 8'hA5);
        run_op8(8'h7F, 8'h80);
    endtask

    task automatic test_back_to_back();
        int   k;
        int   ndone;
        int   t_done[2];
        exp_t e;
        q8.push_back(model(32'h00, 32'h00, 8));
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
        k = 0; ndone = 0;
        while (ndone < 2 && k < 80) begin
            @(negedge clk);
            k++;
            if (k == 3) begin
                // Mid-RUN change: ignored by op 1, captured by op 2.
                a8 = 8'hAA; b8 = 8'h11;
                q8.push_back(model(32'hAA, 32'h11, 8));
            end
            if (ndone == 1 && k == t_done[0] + 1) begin
                n_vec++;
                if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle_gap: got busy=%b done=%b, required 0/0", busy8, done8);
                end
            end
            if (done8) begin
                e = q8.pop_front();
                n_vec++;
                if ({diff8, bo8, ov8} !== {e.diff[7:0], e.bo, e.ov}) begin
                    n_bad++;
                    $display("FAIL b2b_result_%0d: got diff=%h bo=%b ov=%b, required diff=%h bo=%b ov=%b",
                             ndone, diff8, bo8, ov8, e.diff[7:0], e.bo, e.ov);
                end
                t_done[ndone] = k;
                ndone++;
            end
            if (ndone == 1 && busy8) start8 = 1'b0;
        end
        start8 = 1'b0;
        n_vec++;
        if (ndone < 2) begin
            n_bad++;
            $display("FAIL b2b_timeout: got %0d done pulses, required 2", ndone);
            q8.delete();
        end else if (t_done[1] - t_done[0] !== 10) begin
            n_bad++;
            $display("FAIL b2b_period: got %0d cycles between dones, required 10", t_done[1] - t_done[0]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int ndone;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy8, done8, diff8, bo8, ov8} !== 12'd0) begin
            n_bad++;
            $display("FAIL abort_zero: got busy=%b done=%b diff=%h bo=%b ov=%b, required all 0",
                     busy8, done8, diff8, bo8, ov8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        n_vec++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d busy/done cycles after abort, required 0", ndone);
        end
        run_op8(8'h0A, 8'h03);
    endtask

    task automatic test_random();
        repeat (1000) run_op8(8'($urandom), 8'($urandom));
        repeat (1000) run_op16(16'($urandom), 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_hold();
        test_overflow_edges();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor. It computes diff = a - b, one bit per clock, LSB first, using a registered borrow.
- Operands are captured on a start handshake. Completion is flagged with a one-cycle done pulse.
- It is the subtraction counterpart to the team's combinational adder cells. It is intended for area-constrained datapaths where a WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  registered a - b, modulo 2^WIDTH.
- borrow_out  output  1  unsigned borrow; 1 iff a < b as unsigned.
- overflow  output  1  signed (two's complement) overflow of a - b.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; busy=0, done=0, diff=0, borrow_out=0, overflow=0. Internal shift registers, borrow flop and bit counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load a_sh<=a, b_sh<=b, borrow<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Full-subtract a_sh[0] - b_sh[0] - borrow.
  - Shift the difference bit into the MSB of the result shift register.
  - Shift a_sh and b_sh right by 1.
  - Update the borrow flop and increment cnt.
  - On the edge that processes bit WIDTH-1: go to DONE, and register diff, borrow_out and overflow from that final bit.
- DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
- Latency:
  - If start is sampled at edge E0, done is high in the cycle following edge E(WIDTH).
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- Signals derived from state: busy = (state==RUN); done = (state==DONE).
- Output hold: diff, borrow_out and overflow hold their last result until the next operation's DONE. They are not cleared on start.
- start outside IDLE (RUN or DONE) is ignored, with no queuing. a and b may change freely after the accepted edge.
- overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]). The captured operand MSBs are used for this.
- Borrow rule: a full-subtract borrow-out = ~x&y | ~(x^y)&bin.
- Counter width is $clog2(WIDTH). Terminal condition is cnt == WIDTH-1.
- Reset asserted mid-operation: immediate abort to IDLE with all outputs zeroed. No done is produced for the aborted operation.
- Equal operands: diff=0, borrow_out=0, overflow=0.

Decomposition:
- Shared package arith_pkg: FSM state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- Sub-module half_subtractor (x, y, d, bout), with d = x^y and bout = ~x&y.
- The full-subtract bit cell inside serial_subtractor is two half_subtractor instances, with bout = bout1 | bout2.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, start one cycle -> busy for 8 cycles; done at edge 8 after start; diff=0x23, borrow_out=0, overflow=0.
- a=0x12, b=0x35 -> diff=0xDD, borrow_out=1, overflow=0. Outputs hold through 5 idle cycles.
- a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- a=0x00, b=0x00 with start held high continuously -> second operation begins only after DONE→IDLE. done pulses are exactly WIDTH+2 cycles apart. Changing a/b mid-RUN does not affect the result.
- Start a=0x55, b=0x0F, assert rst_n=0 at RUN cycle 4 -> outputs 0 immediately, no done pulse. After release, a=0x0A, b=0x03 -> diff=0x07.
- Random regression, 1000 operations at WIDTH=8 and WIDTH=16 -> diff, borrow_out and overflow match the reference model every time.
